// File: rtl/fft_butterfly_r2.sv
// fft_butterfly_r2: radix-2 DIT butterfly, X0 = (A+WB)/2, X1 = (A-WB)/2, with a per-pass index counter.
// Latency: 2 cycles from input acceptance to output, 1 butterfly per cycle sustained.
// Backpressure: ready_out low holds S2 (outputs stable); S1 holds once full; ready_in = ~v1 | ~v2 | ready_out.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   a_in, wb_in           complex inputs {real[2*DW-1:DW], imag[DW-1:0]}, signed
//   valid_in / ready_in   input handshake
//   x0_out, x1_out        complex results, same packing
//   valid_out / ready_out output handshake
//   last_out, bfly_idx    butterfly index within the pass, last flags index N_POINTS/2-1
//
// Optional feature: define BFLY_ROUND_EN to round half-up ((v+1)>>>1) instead of truncating.
module fft_butterfly_r2 #(
    parameter int DW        = 12,
    parameter int N_POINTS  = 1024,
    localparam int IW       = $clog2(N_POINTS) - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*DW-1:0]   a_in,
    input  logic [2*DW-1:0]   wb_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [2*DW-1:0]   x0_out,
    output logic [2*DW-1:0]   x1_out,
    output logic              valid_out,
    input  logic              ready_out,
    output logic              last_out,
    output logic [IW-1:0]     bfly_idx
);

    // Stage 1 registers
    logic [2*DW-1:0] a1_q, wb1_q;
    logic            v1_q;
    logic [IW-1:0]   idx1_q;
    logic [IW-1:0]   cnt_q, cnt_d;

    // Stage 2 registers
    logic [2*DW-1:0] x0_q, x1_q, x0_d, x1_d;
    logic            v2_q;
    logic [IW-1:0]   idx2_q;
    logic            last2_q;

    logic adv1, adv2, accept;

    assign adv2     = ~v2_q | ready_out;
    assign adv1     = ~v1_q | adv2;
    assign ready_in = adv1;
    assign accept   = valid_in & adv1;

    // N_POINTS/2 is a power of two, so the natural IW-bit wrap gives the pass boundary.
    assign cnt_d = cnt_q + IW'(1);

    // Halve a (DW+2)-bit signed value down to DW bits. Two guard bits keep the
    // rounding increment from wrapping before the shift.
    function automatic logic [DW-1:0] halve(input logic signed [DW+1:0] v);
        logic signed [DW+1:0] t;
`ifdef BFLY_ROUND_EN
        t = v + (DW+2)'(1);
`else
        t = v;
`endif
        t = t >>> 1;
        return t[DW-1:0];
    endfunction

    always_comb begin
        logic signed [DW+1:0] ar, ai, br, bi;
        ar = {{2{a1_q[2*DW-1]}},  a1_q[2*DW-1:DW]};
        ai = {{2{a1_q[DW-1]}},    a1_q[DW-1:0]};
        br = {{2{wb1_q[2*DW-1]}}, wb1_q[2*DW-1:DW]};
        bi = {{2{wb1_q[DW-1]}},   wb1_q[DW-1:0]};
        x0_d = {halve(ar + br), halve(ai + bi)};
        x1_d = {halve(ar - br), halve(ai - bi)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q   <= '0;
            wb1_q  <= '0;
            v1_q   <= 1'b0;
            idx1_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (adv1) begin
                v1_q <= valid_in;
            end
            if (accept) begin
                a1_q   <= a_in;
                wb1_q  <= wb_in;
                idx1_q <= cnt_q;
                cnt_q  <= cnt_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q    <= '0;
            x1_q    <= '0;
            v2_q    <= 1'b0;
            idx2_q  <= '0;
            last2_q <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
            // Only load on a real S1 word so a bubble leaves the last result in place.
            if (v1_q) begin
                x0_q    <= x0_d;
                x1_q    <= x1_d;
                idx2_q  <= idx1_q;
                last2_q <= (idx1_q == {IW{1'b1}});
            end
        end
    end

    assign x0_out    = x0_q;
    assign x1_out    = x1_q;
    assign valid_out = v2_q;
    assign bfly_idx  = idx2_q;
    assign last_out  = last2_q & v2_q;

endmodule
